pipe_stage_skid_reg: RTL
========================

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits, legal range 1..1024.
REQ-002 Parameter CTRL_W, default 16: control-field width in bits, legal range 1..64.
REQ-003 Parameter CNT_W, default 16: bubble-counter width in bits, legal range 2..32.
REQ-004 Parameter CLEAR_ON_FLUSH, default 1: when 1, flush also zeroes the stored data and control fields.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 rst  in  1: asynchronous, active-low reset; the only reset in the block.
REQ-007 in_valid  in  1: upstream offers a beat.
REQ-008 in_ready  out  1: stage accepts a beat; driven directly from a flop.
REQ-009 in_data  in  DATA_W: upstream payload.
REQ-010 in_ctrl  in  CTRL_W: upstream control fields.
REQ-011 out_valid  out  1: stage presents a beat.
REQ-012 out_ready  in  1: downstream accepts the presented beat.
REQ-013 out_data  out  DATA_W: presented payload.
REQ-014 out_ctrl  out  CTRL_W: presented control fields.
REQ-015 flush  in  1: synchronous pipeline kill.
REQ-016 cnt_clr  in  1: synchronous clear of bubble_cnt.
REQ-017 occupancy  out  2: number of held beats, 0..2.
REQ-018 bubble_cnt  out  CNT_W: saturating count of bubble cycles.

Function
REQ-019 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-020 Storage is two entries: MAIN, which drives out_data/out_ctrl, and SKID.
REQ-021 FSM states:
  - EMPTY: occupancy 0, out_valid 0.
  - ONE: occupancy 1, out_valid 1.
  - FULL: occupancy 2, out_valid 1.
REQ-022 in_ready = 1 in EMPTY and ONE, and 0 in FULL; the value is held in a flop updated with the next state.
REQ-023 Transitions from EMPTY: in_fire -> ONE, with MAIN <= in.
REQ-024 Transitions from ONE:
  - in_fire & !out_fire -> FULL, with SKID <= in.
  - in_fire & out_fire -> ONE, with MAIN <= in.
  - !in_fire & out_fire -> EMPTY.
  - otherwise the state holds.
REQ-025 Transitions from FULL: out_fire -> ONE, with MAIN <= SKID; otherwise the state holds.
REQ-026 Latency is one cycle: a beat accepted in EMPTY appears on the output in the next cycle.
REQ-027 Throughput is one beat per cycle when out_ready is held at 1.
REQ-028 Ordering is strict FIFO; no beat is duplicated or lost except by flush.
REQ-029 While out_valid = 1 and out_ready = 0, out_data and out_ctrl SHALL stay stable.
REQ-030 flush has highest priority: the next state is EMPTY, in_ready goes to 1, and a beat offered by in_fire in the flush cycle is discarded.
REQ-031 An out_fire in the flush cycle counts as delivered.
REQ-032 When flush = 1 and CLEAR_ON_FLUSH = 1, MAIN and SKID are zeroed; when CLEAR_ON_FLUSH = 0, they are left unchanged.
REQ-033 bubble_cnt increments by 1 in any cycle with out_ready & !out_valid, and saturates at 2^CNT_W-1.
REQ-034 cnt_clr sets bubble_cnt to 0, overriding a simultaneous increment.

Reset
REQ-035 While rst = 0, regardless of clk, the block SHALL hold:
  - state EMPTY, out_valid 0, in_ready 1, occupancy 0;
  - out_data 0, out_ctrl 0, SKID 0, bubble_cnt 0.
REQ-036 A reset asserted mid-operation discards all held beats immediately.
REQ-037 No beat is accepted on the first clk edge after rst deasserts unless the synchronous logic sees in_valid = 1 and in_ready = 1 at that edge.

Verification
REQ-038 Streaming: in_valid = 1 with data 1,2,3,4 and out_ready = 1 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after acceptance, occupancy 1.
REQ-039 Backpressure:
  - stimulus: out_ready = 0 while beats A,B are sent;
  - response: occupancy reaches 2, in_ready goes to 0 the next cycle, and out_data holds A;
  - then out_ready = 1 -> A, then B, with in_ready back to 1 after A leaves.
REQ-040 Flush:
  - stimulus: FULL state, then flush = 1 together with in_valid = 1 (data C);
  - response: next cycle out_valid 0, occupancy 0, out_data 0, and C never appears;
  - repeat with CLEAR_ON_FLUSH = 0: out_data retains its old value.
REQ-041 Bubble counter (CNT_W = 2): 5 cycles of out_ready = 1 with no input -> bubble_cnt 1,2,3,3,3; then cnt_clr -> 0.
REQ-042 Asynchronous reset: drive rst low between clock edges while FULL -> outputs reach reset values without waiting for clk; after release the stage streams normally.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_reg
// Purpose  : Two-entry skid-buffered pipeline stage with flush and bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int DATA_W         = 128,
  parameter int CTRL_W         = 16,
  parameter int CNT_W          = 16,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [1:0]         r_occ;
  logic [DATA_W-1:0]  r_main_data;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [DATA_W-1:0]  r_skid_data;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [CNT_W-1:0]   r_bubble;

  logic               w_in_fire;
  logic               w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Handshake flags and occupancy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      if (CLEAR_ON_FLUSH) begin
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_occ       <= 2'd1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state     <= ST_FULL;
            r_in_ready  <= 1'b0;
            r_occ       <= 2'd2;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end else if (w_in_fire && w_out_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state     <= ST_ONE;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd1;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occ       <= 2'd0;
        end
      endcase
    end
  end

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble <= '0;
    end else if (cnt_clr) begin
      r_bubble <= '0;
    end else if (out_ready && !r_out_valid && (r_bubble != '1)) begin
      r_bubble <= r_bubble + c_cnt_one;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main_data;
  assign out_ctrl   = r_main_ctrl;
  assign occupancy  = r_occ;
  assign bubble_cnt = r_bubble;

endmodule
`default_nettype wire
